// File: rtl/regfile_sum_ctrl_rtl_if.sv
// regfile_sum_ctrl_rtl_if: input stream, regfile ports and sum output of the load-and-reduce controller
interface regfile_sum_ctrl_rtl_if;
    logic       in_val;
    logic       in_rdy;
    logic [3:0] in_data;
    logic       rf_wen;
    logic [1:0] rf_waddr;
    logic [3:0] rf_wdata;
    logic [1:0] rf_raddr;
    logic [3:0] rf_rdata;
    logic       out_val;
    logic       out_rdy;
    logic [5:0] out_sum;
    modport master (
        output in_val, in_data, rf_rdata, out_rdy,
        input  in_rdy, rf_wen, rf_waddr, rf_wdata, rf_raddr, out_val, out_sum
    );
    modport slave (
        input  in_val, in_data, rf_rdata, out_rdy,
        output in_rdy, rf_wen, rf_waddr, rf_wdata, rf_raddr, out_val, out_sum
    );
endinterface

// File: rtl/regfile_sum_ctrl_rtl.sv
// regfile_sum_ctrl_rtl: loads four words into a 4x4 regfile, reads them back and emits their 6-bit sum
module regfile_sum_ctrl_rtl (
    input logic clk,
    input logic rst,
    regfile_sum_ctrl_rtl_if.slave bus
);
    typedef enum logic [1:0] {LOAD, SUM, DONE} state_t;
    state_t     state;
    logic [1:0] cnt;
    logic [5:0] acc;
    assign bus.in_rdy   = state == LOAD;
    assign bus.rf_wen   = bus.in_val & bus.in_rdy;
    assign bus.rf_waddr = cnt;
    assign bus.rf_wdata = bus.in_data;
    assign bus.rf_raddr = state == SUM ? cnt : 2'd0;
    assign bus.out_val  = state == DONE;
    assign bus.out_sum  = acc;
    // cnt wraps naturally from 3 to 0 on every phase change
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= LOAD;
            cnt   <= 2'd0;
            acc   <= 6'd0;
        end else begin
            case (state)
                LOAD: if (bus.in_val) begin
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= SUM;
                        acc   <= 6'd0;
                    end
                end
                SUM: begin
                    acc <= acc + {2'b00, bus.rf_rdata};
                    cnt <= cnt + 2'd1;
                    if (cnt == 2'd3) state <= DONE;
                end
                DONE: if (bus.out_rdy) begin
                    state <= LOAD;
                    cnt   <= 2'd0;
                    acc   <= 6'd0;
                end
                default: state <= LOAD;
            endcase
        end
    end
endmodule

// File: doc/regfile_sum_ctrl_rtl.md
# regfile_sum_ctrl_rtl

Load-and-reduce controller wrapped around the 4-entry, 4-bit, 1r1w register file. It accepts a stream of four 4-bit words over a val/rdy handshake and writes them to regfile entries 0..3 through the regfile write port. It then reads the four entries back through the regfile read port, one per cycle, and presents their 6-bit sum on a val/rdy output. It drives every regfile input and consumes `rdata`, so it sits directly in front of and behind the regfile in the datapath.

## Interface
Parameters:
- None. Geometry is fixed: 4 entries × 4 bits, 6-bit sum.

Ports:
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: reset; synchronous, active-low (0 = reset, sampled on rising `clk`).
- `in_val` input 1: input word valid.
- `in_rdy` output 1: block can accept an input word.
- `in_data` input 4: input word.
- `rf_wen` output 1: regfile write enable.
- `rf_waddr` output 2: regfile write address.
- `rf_wdata` output 4: regfile write data.
- `rf_raddr` output 2: regfile read address.
- `rf_rdata` input 4: regfile read data; combinational from `rf_raddr`.
- `out_val` output 1: sum valid.
- `out_rdy` input 1: consumer accepts sum.
- `out_sum` output 6: sum of the four entries.

## Operation
State registers:
- `state`: one of LOAD, SUM, DONE.
- `cnt`: 2 bits, word/entry index.
- `acc`: 6 bits, running sum.

Combinational outputs:
- `in_rdy` = (state == LOAD).
- `rf_wen` = `in_val` & `in_rdy`.
- `rf_waddr` = `cnt`.
- `rf_wdata` = `in_data`.
- `rf_raddr` = `cnt` in SUM, otherwise 0.
- `out_val` = (state == DONE).
- `out_sum` = `acc`.

LOAD:
- On each accepted word (`in_val` & `in_rdy`), the regfile writes entry `cnt` at the same edge, and `cnt` increments.
- If no word is accepted, state is held.
- The accept with `cnt`==3 moves to SUM with `cnt` = 0 (wrap) and `acc` = 0.

SUM:
- Every cycle: `acc` <= `acc` + zero-extended `rf_rdata`, and `cnt` increments.
- At `cnt`==3, move to DONE.
- No stalls; `in_val` is ignored.

DONE:
- `acc` is held.
- When `out_rdy` = 1, move to LOAD with `cnt` = 0 and `acc` = 0.
- `in_rdy` is 0 throughout DONE, so no input is accepted in the same cycle as the output handshake.

Width and arithmetic:
- Maximum sum is 4 × 15 = 60, which is below 64, so no overflow handling is needed.

Other rules:
- `out_rdy` is ignored outside DONE.
- The block never clears regfile contents; entries persist across reset and across passes.

## Timing
Reset values (the edge with `rst`=0):
- `state` = LOAD, `cnt` = 0, `acc` = 0.
- Resulting outputs: `in_rdy`=1, `out_val`=0, `out_sum`=0, `rf_raddr`=0, `rf_waddr`=0.
- `rf_wen` follows `in_val` combinationally once in LOAD.

Reset timing:
- Reset overrides all transitions, including mid-LOAD, mid-SUM and DONE-with-`out_rdy`.
- A partially loaded pass is discarded. Already-written entries remain in the regfile, but the next pass restarts at entry 0.

Write/read ordering:
- A write lands at the accepting edge.
- The regfile read is combinational, so SUM cycle 0 (entry 0) sees data written in the final LOAD cycle.

Latency:
- 4 accept edges, then 4 SUM cycles.
- `out_val` rises exactly 4 cycles after the edge that accepts word 3.
- Minimum pass period: 4 (load) + 4 (sum) + 1 (DONE with `out_rdy`=1) = 9 cycles.

Handshake:
- A transfer occurs on a rising edge with val & rdy both 1.
- `out_sum` is stable while `out_val`=1 and `out_rdy`=0.

## Test plan
- Reset then back-to-back inputs 1,2,3,4 with `out_rdy`=1 -> `rf_wen`=1 with `rf_waddr` 0,1,2,3 on successive cycles; `out_val`=1 with `out_sum`=10 exactly 4 cycles after the 4th accept; `in_rdy`=1 the next cycle.
- Inputs 15,15,15,15 -> `out_sum`=60 (max, no wrap).
- Inputs 5,0,9,2 with `in_val` gapped (1,0,0,1,...) and `out_rdy` held 0 for 3 DONE cycles -> writes occur only on val cycles; `out_sum`=16 held stable; `in_rdy`=0 until the cycle after `out_rdy`=1.
- Two passes: 1,1,1,1 then 7,0,0,0 -> sums 4 then 7; second pass overwrites all entries and `acc` restarts at 0.
- Reset asserted after 2 accepts of pass (3,3), then inputs 1,2,3,4 -> `cnt` restarts at 0; `out_sum`=10 (stale entries fully overwritten).
- Reset asserted during SUM cycle 2, and separately during DONE -> next cycle `state`=LOAD, `out_val`=0, `out_sum`=0, `in_rdy`=1.
